// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : reset_sequencer
//  Purpose  : Waits for a filtered PLL lock, then releases CHANNELS active-low
//             resets one at a time, STAGE_DELAY cycles apart (bit 0 first).
//             A lock loss during or after sequencing drops every channel at
//             once and restarts the sequence. Lock losses are counted in a
//             saturating 8-bit fault counter.
//  Optional : define RST_SEQ_SW_RESET_EN to add iSW_RESET, a software restart
//             that behaves like a lock loss but is not counted as a fault.
//  Ports    : iCLK        - clock, rising edge
//             iRESETn     - asynchronous active-low reset
//             iPLL_LOCKED - PLL lock indication, synchronous to iCLK
//             iSW_RESET   - software restart (only with RST_SEQ_SW_RESET_EN)
//             oRESETn     - per-channel active-low resets (thermometer code)
//             oREADY      - high once every channel is released
//             oFAULT_CNT  - saturating count of lock losses
//  Revision : 1.0 - initial release
// ============================================================================
module reset_sequencer #(
    parameter int CHANNELS    = 4,
    parameter int CNT_WIDTH   = 6,
    parameter int LOCK_FILTER = 8,
    parameter int STAGE_DELAY = 32
) (
    input  logic                iCLK,
    input  logic                iRESETn,
    input  logic                iPLL_LOCKED,
`ifdef RST_SEQ_SW_RESET_EN
    input  logic                iSW_RESET,
`endif
    output logic [CHANNELS-1:0] oRESETn,
    output logic                oREADY,
    output logic [7:0]          oFAULT_CNT
);

    localparam int KW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [CNT_WIDTH-1:0] c_LF_LAST    = CNT_WIDTH'(LOCK_FILTER - 1);
    localparam logic [CNT_WIDTH-1:0] c_SD_LAST    = CNT_WIDTH'(STAGE_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [KW-1:0]        c_LAST_STAGE = KW'(CHANNELS - 1);
    localparam logic [KW-1:0]        c_STAGE_ONE  = KW'(1);

    typedef enum logic [1:0] {
        LOCKWAIT = 2'd0,
        RELEASE  = 2'd1,
        RUN      = 2'd2
    } state_t;

    state_t                state_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [KW-1:0]         stage_q;
    logic [CHANNELS-1:0]   resetn_q;
    logic                  ready_q;
    logic [7:0]            fault_q;

    logic                  w_sw_reset;

`ifdef RST_SEQ_SW_RESET_EN
    assign w_sw_reset = iSW_RESET;
`else
    assign w_sw_reset = 1'b0;
`endif

    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            state_q  <= LOCKWAIT;
            cnt_q    <= '0;
            stage_q  <= '0;
            resetn_q <= '0;
            ready_q  <= 1'b0;
            fault_q  <= 8'd0;
        end else begin
            case (state_q)
                LOCKWAIT: begin
                    // Any low sample restarts the lock filter from zero.
                    if (!iPLL_LOCKED || w_sw_reset) begin
                        cnt_q <= '0;
                    end else if (cnt_q == c_LF_LAST) begin
                        state_q <= RELEASE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + c_CNT_ONE;
                    end
                end

                RELEASE, RUN: begin
                    // Abort has priority over a release landing on the same edge.
                    if (!iPLL_LOCKED || w_sw_reset) begin
                        state_q  <= LOCKWAIT;
                        cnt_q    <= '0;
                        stage_q  <= '0;
                        resetn_q <= '0;
                        ready_q  <= 1'b0;
                        // Only a genuine lock loss is a fault.
                        if (!iPLL_LOCKED && (fault_q != 8'hFF)) begin
                            fault_q <= fault_q + 8'd1;
                        end
                    end else if (state_q == RELEASE) begin
                        if (cnt_q == c_SD_LAST) begin
                            // Setting bits in ascending order keeps the
                            // output a thermometer code.
                            resetn_q[stage_q] <= 1'b1;
                            cnt_q             <= '0;
                            if (stage_q == c_LAST_STAGE) begin
                                state_q <= RUN;
                                ready_q <= 1'b1;
                            end else begin
                                stage_q <= stage_q + c_STAGE_ONE;
                            end
                        end else begin
                            cnt_q <= cnt_q + c_CNT_ONE;
                        end
                    end
                end

                default: begin
                    state_q <= LOCKWAIT;
                end
            endcase
        end
    end

    assign oRESETn    = resetn_q;
    assign oREADY     = ready_q;
    assign oFAULT_CNT = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reset_sequencer
//  Purpose  : Self-checking bench for reset_sequencer. The reference model
//             tracks only the number of consecutive high lock samples and the
//             fault count; channel k must be released once that run length
//             reaches LOCK_FILTER+(k+1)*STAGE_DELAY. Directed scenarios add
//             hand-computed literal checks at the key edges.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

    localparam int CH = 4;
    localparam int CW = 6;
    localparam int LF = 8;
    localparam int SD = 32;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          lock  = 1'b0;
    logic          sw    = 1'b0;
    logic [CH-1:0] o_resetn;
    logic          o_ready;
    logic [7:0]    o_fault;

    int vectors     = 0;
    int miscompares = 0;
    int e           = 0;

    // Model state: length of the current run of high lock samples, faults.
    int m_n     = 0;
    int m_fault = 0;

    always #5 clk = ~clk;

    reset_sequencer #(
        .CHANNELS   (CH),
        .CNT_WIDTH  (CW),
        .LOCK_FILTER(LF),
        .STAGE_DELAY(SD)
    ) dut (
        .iCLK       (clk),
        .iRESETn    (rst_n),
        .iPLL_LOCKED(lock),
`ifdef RST_SEQ_SW_RESET_EN
        .iSW_RESET  (sw),
`endif
        .oRESETn    (o_resetn),
        .oREADY     (o_ready),
        .oFAULT_CNT (o_fault)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n     <= 0;
            m_fault <= 0;
        end else if (!lock) begin
            // Run length >= LF means sequencing had started: that is a fault.
            if (m_n >= LF && m_fault < 255) m_fault <= m_fault + 1;
            m_n <= 0;
        end else if (sw) begin
            m_n <= 0;
        end else if (m_n < 1000000) begin
            m_n <= m_n + 1;
        end
    end

    function automatic logic [CH-1:0] exp_resetn(input int n);
        logic [CH-1:0] r;
        for (int k = 0; k < CH; k++) r[k] = (n >= LF + (k + 1) * SD);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_resetn", 32'(o_resetn), 32'(exp_resetn(m_n)));
        chk("model_ready",  32'(o_ready),  32'(m_n >= LF + CH * SD));
        chk("model_fault",  32'(o_fault),  32'(m_fault));
    end

    task automatic edge_(input logic l);
        lock = l;
        @(posedge clk);
        #2;
        e++;
    endtask

    task automatic run_high(input int n);
        for (int i = 0; i < n; i++) edge_(1'b1);
    endtask

    // Lock high from edge 1; literal pins at the release edges of the defaults.
    task automatic full_sequence(input string tag);
        e = 0;
        run_high(39);
        chk({tag, "_e39"}, 32'(o_resetn), 32'h0);
        run_high(1);
        chk({tag, "_e40"}, 32'(o_resetn), 32'h1);
        run_high(31);
        chk({tag, "_e71"}, 32'(o_resetn), 32'h1);
        run_high(1);
        chk({tag, "_e72"}, 32'(o_resetn), 32'h3);
        run_high(32);
        chk({tag, "_e104"}, 32'(o_resetn), 32'h7);
        run_high(31);
        chk({tag, "_e135_rdy"}, 32'(o_ready), 32'h0);
        run_high(1);
        chk({tag, "_e136"}, 32'(o_resetn), 32'hF);
        chk({tag, "_e136_rdy"}, 32'(o_ready), 32'h1);
        run_high(4);
        chk({tag, "_run_hold"}, 32'(o_resetn), 32'hF);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1 chk("reset_async", {22'b0, o_fault, o_ready, o_resetn}, 32'h0);
        for (int i = 0; i < 3; i++) edge_(1'b0);
        rst_n = 1'b1;
        edge_(1'b0);
        chk("reset_state", {22'b0, o_fault, o_ready, o_resetn}, 32'h0);

        // Default sequence.
        full_sequence("seq1");
        chk("seq1_fault", 32'(o_fault), 32'h0);

        // One-edge loss in RUN drops everything on that edge, then restarts.
        edge_(1'b0);
        chk("loss_run_resetn", 32'(o_resetn), 32'h0);
        chk("loss_run_ready", 32'(o_ready), 32'h0);
        chk("loss_run_fault", 32'(o_fault), 32'h1);
        full_sequence("seq2");

        // Loss on the release edge wins: no release, fault counted.
        edge_(1'b0);
        run_high(39);
        edge_(1'b0);
        chk("loss_on_release_resetn", 32'(o_resetn), 32'h0);
        chk("loss_on_release_fault", 32'(o_fault), 32'h3);

        // Glitch inside lock filter: no fault, release 40 edges after return.
        run_high(5);
        edge_(1'b0);
        chk("lockwait_glitch_fault", 32'(o_fault), 32'h3);
        run_high(39);
        chk("glitch_e39", 32'(o_resetn), 32'h0);
        run_high(1);
        chk("glitch_e40", 32'(o_resetn), 32'h1);

        // Async reset mid-RELEASE at edge 80, then the sequence restarts.
        edge_(1'b0);
        e = 0;
        run_high(80);
        chk("pre_reset_e80", 32'(o_resetn), 32'h3);
        rst_n = 1'b0;
        #1 chk("mid_reset_async", {22'b0, o_fault, o_ready, o_resetn}, 32'h0);
        edge_(1'b1);
        edge_(1'b1);
        rst_n = 1'b1;
        edge_(1'b0);
        full_sequence("seq3");

        // Fault counter saturation.
        for (int i = 0; i < 300; i++) begin
            run_high(LF);
            edge_(1'b0);
        end
        chk("fault_sat", 32'(o_fault), 32'd255);
        run_high(LF + 3);
        edge_(1'b0);
        chk("fault_sat_hold", 32'(o_fault), 32'd255);
        rst_n = 1'b0;
        #1 chk("fault_cleared", 32'(o_fault), 32'h0);
        edge_(1'b0);
        rst_n = 1'b1;
        edge_(1'b0);

`ifdef RST_SEQ_SW_RESET_EN
        // Software restart from RUN: channels drop, no fault, full re-release.
        full_sequence("seq4");
        sw = 1'b1;
        edge_(1'b1);
        sw = 1'b0;
        chk("sw_reset_resetn", 32'(o_resetn), 32'h0);
        chk("sw_reset_fault", 32'(o_fault), 32'h0);
        full_sequence("seq5");
`endif

        edge_(1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 The block SHALL have a parameter CHANNELS, default 4, giving the number of sequenced reset outputs (1..16).
REQ-002 The block SHALL have a parameter CNT_WIDTH, default 6, giving the width of the internal delay counter.
REQ-003 The block SHALL have a parameter LOCK_FILTER, default 8, giving the consecutive locked cycles required before sequencing (1..2^CNT_WIDTH-1).
REQ-004 The block SHALL have a parameter STAGE_DELAY, default 32, giving the cycles between successive channel releases (1..2^CNT_WIDTH-1).
REQ-005 The block SHALL have port iCLK, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-006 The block SHALL have port iRESETn, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port iPLL_LOCKED, input, 1 bit: PLL lock indication, synchronous to iCLK.
REQ-008 The block SHALL have port oRESETn, output, CHANNELS bits: per-channel active-low resets, where bit 0 is released first.
REQ-009 The block SHALL have port oREADY, output, 1 bit: high when all channels are released.
REQ-010 The block SHALL have port oFAULT_CNT, output, 8 bits: saturating count of lock losses.

Function
REQ-011 The block SHALL implement the states LOCKWAIT, RELEASE and RUN, and all outputs SHALL be registered.
REQ-012 In LOCKWAIT, the counter SHALL increment on each edge with iPLL_LOCKED=1 and clear on each edge with iPLL_LOCKED=0; at the edge where the counter equals LOCK_FILTER-1 with lock high, the state SHALL go to RELEASE and the counter SHALL clear.
REQ-013 In RELEASE, the counter SHALL increment each edge; at the edge where the counter equals STAGE_DELAY-1, the block SHALL set oRESETn[k]=1, clear the counter and increment stage index k.
REQ-014 Release of the last channel SHALL move the state to RUN and set oREADY=1 on the same edge.
REQ-015 oRESETn SHALL always be a thermometer code: bit k high implies all bits below k are high.
REQ-016 Channel k SHALL deassert LOCK_FILTER+(k+1)*STAGE_DELAY edges after the first sampled-high edge of iPLL_LOCKED.
REQ-017 An edge with iPLL_LOCKED=0 in RELEASE or RUN SHALL, on that edge, set oRESETn to all zeros, set oREADY=0, clear the counter and k, and enter LOCKWAIT.
REQ-018 A lock loss SHALL increment oFAULT_CNT on the edge where the loss is sampled, saturating at 255.
REQ-019 A lock loss on the same edge as a channel release SHALL take priority, and the release SHALL not occur.
REQ-020 iPLL_LOCKED=0 in LOCKWAIT SHALL not increment oFAULT_CNT.
REQ-021 The counter SHALL never exceed max(LOCK_FILTER, STAGE_DELAY)-1, and there SHALL be no wrap-around.

Reset
REQ-022 Assertion of iRESETn=0 SHALL, asynchronously, force state=LOCKWAIT, counter=0, k=0, oRESETn=0, oREADY=0 and oFAULT_CNT=0.
REQ-023 Deassertion of iRESETn SHALL release no channel directly; channels SHALL be released only through the synchronous sequence, including after a reset applied mid-sequence.

Configuration
REQ-024 When macro RST_SEQ_SW_RESET_EN is defined, the block SHALL add input iSW_RESET (1 bit), which is sampled each edge.
REQ-025 With RST_SEQ_SW_RESET_EN defined, iSW_RESET=1 in RELEASE or RUN SHALL behave as REQ-017 but SHALL not increment oFAULT_CNT; while held high, the block SHALL stay in LOCKWAIT with the counter cleared.
REQ-026 Without RST_SEQ_SW_RESET_EN, the port SHALL be absent and the behaviour SHALL be exactly REQ-011..REQ-021.

Verification
REQ-027 Defaults, lock high from edge 1 -> oRESETn[0..3] rise at edges 40, 72, 104 and 136; oREADY rises at edge 136; oFAULT_CNT=0.
REQ-028 Lock high 5 edges, low 1 edge, then high -> no increment of oFAULT_CNT; oRESETn[0] rises 40 edges after lock returns.
REQ-029 In RUN, drop lock for 1 edge -> oRESETn=0000 and oREADY=0 on that edge; oFAULT_CNT=1; the full sequence repeats with the REQ-027 timing.
REQ-030 300 lock losses from RUN or RELEASE -> oFAULT_CNT=255 and holds; iRESETn pulse -> oFAULT_CNT=0.
REQ-031 iRESETn asserted at edge 80 mid-RELEASE -> outputs 0 immediately without a clock; after release, the sequence restarts per REQ-027.
REQ-032 With RST_SEQ_SW_RESET_EN, a 1-edge iSW_RESET pulse in RUN -> oRESETn=0000, oFAULT_CNT unchanged, and re-release per REQ-016.
